io_bus_arbiter: RTL and testbench

//  Shares the single data-memory/IO port between the Risc32 core io_* bus and one auxiliary

---
 rtl/io_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
// Shares the single data-memory/IO port between the single-cycle core bus and
// one auxiliary requester (program loader / debug DMA). The core cannot stall,
// so it always owns the port combinationally whenever it reads or writes. An
// aux request is latched in IDLE, issued in the first cycle the core leaves the
// port free, and acknowledged with a one-cycle registered pulse.
//
// Ports
//   clk, rst_n            : clock (rising edge), synchronous active-low reset
//   core_*                : core io_* bus; core_read_value = mem_read_value
//   aux_req/aux_we/...    : aux request (level, held until aux_ack) and fields
//   aux_ack               : one-cycle completion pulse (registered)
//   aux_read_value        : read data, registered, held until the next aux read
//   aux_starved           : aux has waited STARVE_LIMIT busy cycles in ISSUE
//   mem_*                 : shared memory/IO port (combinational read data in)
// -----------------------------------------------------------------------------
module io_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] core_address,
    input  logic [DATA_W-1:0] core_write_value,
    output logic [DATA_W-1:0] core_read_value,
    input  logic              core_write_en,
    input  logic              core_read_en,
    input  logic [2:0]        core_data_size,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_address,
    input  logic [DATA_W-1:0] aux_write_value,
    input  logic [2:0]        aux_data_size,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_read_value,
    output logic              aux_starved,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_value,
    input  logic [DATA_W-1:0] mem_read_value,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [2:0]        mem_data_size
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t            state_q,        state_d;
    logic              aux_we_q,       aux_we_d;
    logic [ADDR_W-1:0] aux_addr_q,     aux_addr_d;
    logic [DATA_W-1:0] aux_wdata_q,    aux_wdata_d;
    logic [2:0]        aux_size_q,     aux_size_d;
    logic [CNT_W-1:0]  starve_cnt_q,   starve_cnt_d;
    logic              aux_ack_q,      aux_ack_d;
    logic [DATA_W-1:0] aux_rdata_q,    aux_rdata_d;
    logic              aux_starved_q,  aux_starved_d;

    logic              core_busy;

    assign core_busy       = core_read_en | core_write_en;
    assign core_read_value = mem_read_value;
    assign aux_ack         = aux_ack_q;
    assign aux_read_value  = aux_rdata_q;
    assign aux_starved     = aux_starved_q;

    // Port mux: core always wins; the aux access only drives an otherwise idle port.
    always_comb begin
        mem_address     = '0;
        mem_write_value = '0;
        mem_data_size   = 3'b000;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        if (core_busy) begin
            mem_address     = core_address;
            mem_write_value = core_write_value;
            mem_data_size   = core_data_size;
            mem_write_en    = core_write_en;
            mem_read_en     = core_read_en;
        end else if (state_q == ST_ISSUE) begin
            mem_address     = aux_addr_q;
            mem_write_value = aux_wdata_q;
            mem_data_size   = aux_size_q;
            mem_write_en    = aux_we_q;
            mem_read_en     = ~aux_we_q;
        end else begin
            mem_address     = '0;
            mem_write_value = '0;
            mem_data_size   = 3'b000;
            mem_write_en    = 1'b0;
            mem_read_en     = 1'b0;
        end
    end

    // Next-state logic: request latch, wait/issue decision, starvation counter.
    always_comb begin
        state_d      = state_q;
        aux_we_d     = aux_we_q;
        aux_addr_d   = aux_addr_q;
        aux_wdata_d  = aux_wdata_q;
        aux_size_d   = aux_size_q;
        starve_cnt_d = starve_cnt_q;
        aux_rdata_d  = aux_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (aux_req) begin
                    aux_we_d    = aux_we;
                    aux_addr_d  = aux_address;
                    aux_wdata_d = aux_write_value;
                    aux_size_d  = aux_data_size;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (core_busy) begin
                    // Saturate so aux_starved stays up for as long as the core hogs the port.
                    if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                    state_d = ST_ISSUE;
                end else begin
                    // The mux is driving the latched aux access this cycle.
                    if (!aux_we_q) begin
                        aux_rdata_d = mem_read_value;
                    end else begin
                        aux_rdata_d = aux_rdata_q;
                    end
                    starve_cnt_d = '0;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        aux_ack_d     = (state_d == ST_ACK);
        aux_starved_d = (starve_cnt_d == STARVE_MAX);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            aux_we_q      <= 1'b0;
            aux_addr_q    <= '0;
            aux_wdata_q   <= '0;
            aux_size_q    <= 3'b000;
            starve_cnt_q  <= '0;
            aux_ack_q     <= 1'b0;
            aux_rdata_q   <= '0;
            aux_starved_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            aux_we_q      <= aux_we_d;
            aux_addr_q    <= aux_addr_d;
            aux_wdata_q   <= aux_wdata_d;
            aux_size_q    <= aux_size_d;
            starve_cnt_q  <= starve_cnt_d;
            aux_ack_q     <= aux_ack_d;
            aux_rdata_q   <= aux_rdata_d;
            aux_starved_q <= aux_starved_d;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arbiter
// Directed bench for io_bus_arbiter. A transaction-level model of the aux
// request (pending / waiting / acked) predicts every output each cycle; a
// negedge compare process checks the DUT against it, and the directed tests
// add hand-computed literal expectations.
// Memory word at address a: last write if any, else 0xDEADBEEF at 0x100,
// else 0xC0DE0000 | a[15:0].
// -----------------------------------------------------------------------------
module tb_io_bus_arbiter;

    localparam int LIMIT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] core_address, core_write_value, core_read_value;
    logic        core_write_en, core_read_en;
    logic [2:0]  core_data_size;
    logic        aux_req, aux_we;
    logic [31:0] aux_address, aux_write_value;
    logic [2:0]  aux_data_size;
    logic        aux_ack;
    logic [31:0] aux_read_value;
    logic        aux_starved;
    logic [31:0] mem_address, mem_write_value, mem_read_value;
    logic        mem_write_en, mem_read_en;
    logic [2:0]  mem_data_size;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bit          wvalid [0:255];
    logic [31:0] wdata  [0:255];

    io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_address(core_address), .core_write_value(core_write_value),
        .core_read_value(core_read_value), .core_write_en(core_write_en),
        .core_read_en(core_read_en), .core_data_size(core_data_size),
        .aux_req(aux_req), .aux_we(aux_we), .aux_address(aux_address),
        .aux_write_value(aux_write_value), .aux_data_size(aux_data_size),
        .aux_ack(aux_ack), .aux_read_value(aux_read_value), .aux_starved(aux_starved),
        .mem_address(mem_address), .mem_write_value(mem_write_value),
        .mem_read_value(mem_read_value), .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en), .mem_data_size(mem_data_size)
    );

    always #5 clk = ~clk;

    // Combinational memory read.
    always_comb begin
        if (wvalid[mem_address[9:2]]) mem_read_value = wdata[mem_address[9:2]];
        else if (mem_address == 32'h0000_0100) mem_read_value = 32'hDEADBEEF;
        else mem_read_value = 32'hC0DE_0000 | {16'h0000, mem_address[15:0]};
    end

    // Memory write port.
    always @(posedge clk) begin
        if (mem_write_en) begin
            wvalid[mem_address[9:2]] <= 1'b1;
            wdata[mem_address[9:2]]  <= mem_write_value;
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (wvalid[a[9:2]]) return wdata[a[9:2]];
        else if (a == 32'h0000_0100) return 32'hDEADBEEF;
        else return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_pend;   // request accepted, not yet on the port
    bit          m_ack;    // completion pulse due this cycle
    int          m_wait;   // busy cycles spent waiting
    logic [31:0] m_rdata;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_size;

    // Model update at each active edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_ack <= 1'b0; m_wait <= 0; m_rdata <= 32'h0;
            m_we <= 1'b0; m_addr <= 32'h0; m_wdata <= 32'h0; m_size <= 3'b000;
        end else if (m_ack) begin
            m_ack <= 1'b0;
        end else if (m_pend) begin
            if (core_read_en || core_write_en) begin
                m_wait <= (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
            end else begin
                m_pend <= 1'b0;
                m_wait <= 0;
                m_ack  <= 1'b1;
                if (!m_we) m_rdata <= mem_word(m_addr);
            end
        end else if (aux_req) begin
            m_pend <= 1'b1; m_we <= aux_we; m_addr <= aux_address;
            m_wdata <= aux_write_value; m_size <= aux_data_size;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] ea, ed;
            logic [2:0]  es;
            logic        ew, er;
            if (core_read_en || core_write_en) begin
                ea = core_address; ed = core_write_value; es = core_data_size;
                ew = core_write_en; er = core_read_en;
            end else if (m_pend) begin
                ea = m_addr; ed = m_wdata; es = m_size; ew = m_we; er = !m_we;
            end else begin
                ea = 32'h0; ed = 32'h0; es = 3'b000; ew = 1'b0; er = 1'b0;
            end
            chk("mem_address", 64'(mem_address), 64'(ea));
            chk("mem_write_value", 64'(mem_write_value), 64'(ed));
            chk("mem_data_size", 64'(mem_data_size), 64'(es));
            chk("mem_write_en", 64'(mem_write_en), 64'(ew));
            chk("mem_read_en", 64'(mem_read_en), 64'(er));
            chk("core_read_value", 64'(core_read_value), 64'(mem_word(ea)));
            chk("aux_ack", 64'(aux_ack), 64'(m_ack));
            chk("aux_read_value", 64'(aux_read_value), 64'(m_rdata));
            chk("aux_starved", 64'(aux_starved), 64'(m_wait >= LIMIT));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        core_read_en = 1'b0; core_write_en = 1'b0; core_address = 32'h0;
        core_write_value = 32'h0; core_data_size = 3'b000;
    endtask

    task automatic aux_set(input bit req, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] sz);
        aux_req = req; aux_we = we; aux_address = a; aux_write_value = d; aux_data_size = sz;
    endtask

    initial begin
        int ack_cyc [3];
        int nack;
        bit chg;
        logic [31:0] t5_addr [3];
        logic [31:0] t5_exp  [3];
        t5_addr[0] = 32'h0C0; t5_addr[1] = 32'h0C4; t5_addr[2] = 32'h0C8;
        t5_exp[0] = 32'hC0DE00C0; t5_exp[1] = 32'hC0DE00C4; t5_exp[2] = 32'hC0DE00C8;

        rst_n = 1'b0;
        core_idle();
        aux_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick(); tick();
        chk_en = 1'b1;
        chk("reset_ack", 64'(aux_ack), 64'd0);
        chk("reset_rdata", 64'(aux_read_value), 64'd0);
        chk("reset_starved", 64'(aux_starved), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: aux read of 0x100, core idle
        aux_set(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        tick(); #1;
        chk("t1_rd_en", 64'(mem_read_en), 64'd1);
        chk("t1_addr", 64'(mem_address), 64'h100);
        tick();
        chk("t1_ack", 64'(aux_ack), 64'd1);
        chk("t1_rdata", 64'(aux_read_value), 64'hDEADBEEF);
        aux_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        chk("t1_ack_drop", 64'(aux_ack), 64'd0);

        // 2: aux write, then core reads it back
        aux_set(1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010);
        tick(); #1;
        chk("t2_wr_en", 64'(mem_write_en), 64'd1);
        chk("t2_addr", 64'(mem_address), 64'h20);
        chk("t2_wdata", 64'(mem_write_value), 64'h12345678);
        chk("t2_size", 64'(mem_data_size), 64'd2);
        tick();
        chk("t2_ack", 64'(aux_ack), 64'd1);
        chk("t2_rdata_kept", 64'(aux_read_value), 64'hDEADBEEF);
        aux_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        core_read_en = 1'b1; core_address = 32'h20; core_data_size = 3'b010;
        #1;
        chk("t2_core_rd", 64'(core_read_value), 64'h12345678);
        tick();
        core_idle();

        // 3: core busy 20 cycles, aux read pending -> starvation
        aux_set(1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
        for (int i = 0; i < 20; i++) begin
            core_read_en = 1'b1; core_address = 32'h200 + 32'(4 * i); core_data_size = 3'b010;
            #1;
            if (i == 16) chk("t3_not_starved", 64'(aux_starved), 64'd0);
            if (i == 17) chk("t3_starved", 64'(aux_starved), 64'd1);
            tick();
        end
        core_idle();
        #1;
        chk("t3_issue_addr", 64'(mem_address), 64'h40);
        chk("t3_still_starved", 64'(aux_starved), 64'd1);
        tick();
        chk("t3_ack", 64'(aux_ack), 64'd1);
        chk("t3_starve_clr", 64'(aux_starved), 64'd0);
        chk("t3_rdata", 64'(aux_read_value), 64'hC0DE0040);
        aux_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();

        // 4: core load and aux read in the same cycle
        core_read_en = 1'b1; core_address = 32'h80; core_data_size = 3'b010;
        aux_set(1'b1, 1'b0, 32'h84, 32'h0, 3'b010);
        #1;
        chk("t4_core_rd0", 64'(core_read_value), 64'hC0DE0080);
        tick();
        core_address = 32'h88;
        #1;
        chk("t4_core_rd1", 64'(core_read_value), 64'hC0DE0088);
        tick();
        core_idle();
        #1;
        chk("t4_issue_addr", 64'(mem_address), 64'h84);
        tick();
        chk("t4_ack", 64'(aux_ack), 64'd1);
        chk("t4_rdata", 64'(aux_read_value), 64'hC0DE0084);
        aux_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();

        // 5: three back-to-back reads, req held
        nack = 0; chg = 1'b0;
        aux_set(1'b1, 1'b0, t5_addr[0], 32'h0, 3'b010);
        for (int c = 0; c < 14; c++) begin
            tick();
            if (chg) begin
                chg = 1'b0;
                if (nack < 3) aux_address = t5_addr[nack];
                else aux_req = 1'b0;
            end
            #1;
            if (aux_ack && nack < 3) begin
                chk("t5_rdata", 64'(aux_read_value), 64'(t5_exp[nack]));
                ack_cyc[nack] = c;
                nack++;
                chg = 1'b1;
            end
        end
        chk("t5_ack_count", 64'(nack), 64'd3);
        if (nack == 3) begin
            chk("t5_gap01", 64'(ack_cyc[1] - ack_cyc[0]), 64'd3);
            chk("t5_gap12", 64'(ack_cyc[2] - ack_cyc[1]), 64'd3);
        end
        aux_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();

        // 6: reset while the aux write waits in ISSUE
        aux_set(1'b1, 1'b1, 32'h30, 32'h55, 3'b010);
        core_read_en = 1'b1; core_address = 32'h04; core_data_size = 3'b010;
        tick();
        core_read_en = 1'b0; core_write_en = 1'b1; core_address = 32'h44;
        core_write_value = 32'hCAFE0044;
        rst_n = 1'b0;
        #1;
        chk("t6_core_wr_in_rst", 64'(mem_write_en), 64'd1);
        chk("t6_core_addr_in_rst", 64'(mem_address), 64'h44);
        tick();
        rst_n = 1'b1;
        core_idle();
        aux_set(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        chk("t6_no_ack", 64'(aux_ack), 64'd0);
        chk("t6_wr_en0", 64'(mem_write_en), 64'd0);
        chk("t6_rd_en0", 64'(mem_read_en), 64'd0);
        chk("t6_addr0", 64'(mem_address), 64'd0);
        chk("t6_rdata0", 64'(aux_read_value), 64'd0);
        tick();
        chk("t6_no_ack_later", 64'(aux_ack), 64'd0);
        chk("t6_aux_not_written", 64'(wvalid[12]), 64'd0);
        chk("t6_core_written", 64'(wdata[17]), 64'hCAFE0044);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
